// File: rtl/entrada_bcd_bin_pkg.sv
// Shared I/O definitions for the BCD <-> binary paths: FSM encodings,
// BCD correction constants and a digit validity helper.
package entrada_bcd_bin_pkg;

   localparam logic [1:0] OCIOSO   = 2'd0;
   localparam logic [1:0] CONVERTE = 2'd1;
   localparam logic [1:0] FIM      = 2'd2;

   localparam logic [3:0] BCD_AJUSTE = 4'd3;
   localparam logic [3:0] BCD_LIMIAR = 4'd8;
   localparam logic [3:0] BCD_MAX    = 4'd9;

   // A nibble outside 0..9 is not a decimal digit.
   function automatic logic digito_invalido(input logic [3:0] dig);
      return (dig > BCD_MAX);
   endfunction

endpackage

// File: rtl/entrada_bcd_bin_if.sv
// Start/ready handshake plus data bus between the I/O instruction logic
// (master) and the BCD-to-binary converter (slave).
interface entrada_bcd_bin_if #(
   parameter int DIGITOS = 4
) ();

   logic                   inicio;
   logic [4*DIGITOS-1:0]   bcd_in;
   logic                   ocupado;
   logic                   pronto;
   logic                   erro;
   logic [31:0]            saida;

   modport master (
      output inicio,
      output bcd_in,
      input  ocupado,
      input  pronto,
      input  erro,
      input  saida
   );

   modport slave (
      input  inicio,
      input  bcd_in,
      output ocupado,
      output pronto,
      output erro,
      output saida
   );

endinterface

// File: rtl/entrada_bcd_bin_ajuste.sv
// Single-digit correction step of reverse double-dabble: after the right
// shift, a digit that reached 8 or more borrowed a "16" that is really a
// "10", so 3 is taken back off.
import entrada_bcd_bin_pkg::*;

module bcd_ajuste_digito (
   input  logic [3:0] dig_i,
   output logic [3:0] dig_o
);

   // Subtract 3 from digits at or above the threshold, pass others through.
   always_comb begin
      dig_o = dig_i;
      if (dig_i >= BCD_LIMIAR) begin
         dig_o = dig_i - BCD_AJUSTE;
      end else begin
         dig_o = dig_i;
      end
   end

endmodule

// File: rtl/entrada_bcd_bin.sv
// Sequential BCD -> binary converter (reverse double-dabble, one shift per
// clock). Working register is {bcd_part, bin_part}; after 4*DIGITOS shifts
// bin_part holds the binary value, which is zero-extended to 32 bits.
import entrada_bcd_bin_pkg::*;

module entrada_bcd_bin #(
   parameter int DIGITOS = 4
) (
   input  logic               clock,
   input  logic               reset,
   entrada_bcd_bin_if.slave   bus
);

   localparam int W     = 4 * DIGITOS;
   localparam int CNT_W = $clog2(W + 1);
   localparam logic [CNT_W-1:0] CNT_ULTIMO = CNT_W'(W - 1);

   logic [1:0]       estado_q, estado_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [W-1:0]     bcd_q, bcd_d;
   logic [W-1:0]     bin_q, bin_d;
   logic             erro_tmp_q, erro_tmp_d;
   logic             erro_q, erro_d;
   logic [31:0]      saida_q, saida_d;
   logic             pronto_q, pronto_d;
   logic             ocupado_q, ocupado_d;

   logic [2*W-1:0]   desloc_s;
   logic [W-1:0]     bcd_ajust_s;
   logic             entrada_invalida_s;

   assign desloc_s = {bcd_q, bin_q} >> 1;

   genvar g;
   generate
      for (g = 0; g < DIGITOS; g++) begin : g_ajuste
         bcd_ajuste_digito u_ajuste (
            .dig_i (desloc_s[W + 4*g +: 4]),
            .dig_o (bcd_ajust_s[4*g +: 4])
         );
      end
   endgenerate

   // Flag the incoming word if any nibble is not a decimal digit.
   always_comb begin
      entrada_invalida_s = 1'b0;
      for (int i = 0; i < DIGITOS; i++) begin
         if (digito_invalido(bus.bcd_in[4*i +: 4])) begin
            entrada_invalida_s = 1'b1;
         end else begin
            entrada_invalida_s = entrada_invalida_s;
         end
      end
   end

   // FSM next-state, shift datapath and output register updates.
   always_comb begin
      estado_d   = estado_q;
      cnt_d      = cnt_q;
      bcd_d      = bcd_q;
      bin_d      = bin_q;
      erro_tmp_d = erro_tmp_q;
      erro_d     = erro_q;
      saida_d    = saida_q;
      pronto_d   = 1'b0;
      case (estado_q)
         OCIOSO: begin
            if (bus.inicio) begin
               bcd_d      = bus.bcd_in;
               bin_d      = '0;
               cnt_d      = '0;
               erro_tmp_d = entrada_invalida_s;
               estado_d   = CONVERTE;
            end else begin
               estado_d   = OCIOSO;
            end
         end
         CONVERTE: begin
            bcd_d = bcd_ajust_s;
            bin_d = desloc_s[W-1:0];
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            if (cnt_q == CNT_ULTIMO) begin
               estado_d = FIM;
            end else begin
               estado_d = CONVERTE;
            end
         end
         FIM: begin
            saida_d  = erro_tmp_q ? 32'd0 : 32'(bin_q);
            erro_d   = erro_tmp_q;
            pronto_d = 1'b1;
            estado_d = OCIOSO;
         end
         default: begin
            estado_d = OCIOSO;
         end
      endcase
      ocupado_d = (estado_d == CONVERTE) || (estado_d == FIM);
   end

   // State and output registers; synchronous active-low reset aborts any conversion.
   always_ff @(posedge clock) begin
      if (!reset) begin
         estado_q   <= OCIOSO;
         cnt_q      <= '0;
         bcd_q      <= '0;
         bin_q      <= '0;
         erro_tmp_q <= 1'b0;
         erro_q     <= 1'b0;
         saida_q    <= 32'd0;
         pronto_q   <= 1'b0;
         ocupado_q  <= 1'b0;
      end else begin
         estado_q   <= estado_d;
         cnt_q      <= cnt_d;
         bcd_q      <= bcd_d;
         bin_q      <= bin_d;
         erro_tmp_q <= erro_tmp_d;
         erro_q     <= erro_d;
         saida_q    <= saida_d;
         pronto_q   <= pronto_d;
         ocupado_q  <= ocupado_d;
      end
   end

   assign bus.ocupado = ocupado_q;
   assign bus.pronto  = pronto_q;
   assign bus.erro    = erro_q;
   assign bus.saida   = saida_q;

endmodule
